angle_frame_encoder: RTL and testbench
======================================

ANGLE_FRAME_ENCODER -- requirements
Module: angle_frame_encoder

Interface
REQ-001 Parameter NCH, default 6, number of angle channels (A1,A2,B1,B2,C1,C2 = channel codes 1..6).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 angle_in  input  NCH*11  packed 11-bit angles; channel k (1-based) at bits [11k-1 : 11k-11].
REQ-005 send_req  input  1  one-cycle pulse: transmit a full angle frame.
REQ-006 run_on  input  1  one-cycle pulse: transmit start-on control byte.
REQ-007 run_off  input  1  one-cycle pulse: transmit start-off control byte.
REQ-008 tx_busy  input  1  UART transmitter busy flag.
REQ-009 tx_data  output  8  byte presented to UART transmitter.
REQ-010 tx_start  output  1  one-cycle strobe: transmitter loads tx_data.
REQ-011 busy  output  1  high from request acceptance until last byte completes.
REQ-012 frame_done  output  1  one-cycle pulse after commit byte of a frame completes.

Function
REQ-013 Frame byte order: for k = 1..NCH: {2'b00,3'b000,k[2:0]}, {2'b01,v[5:0]}, {2'b10,1'b0,v[10:6]}; then commit 8'hC0; 3*NCH+1 bytes (19 at default).
REQ-014 Control bytes: run_on -> 8'hC1, run_off -> 8'hC2, each sent as a standalone single byte.
REQ-015 angle_in SHALL be captured into an internal shadow register on the cycle send_req is accepted; later input changes do not affect the frame in flight.
REQ-016 States: IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE, NEXT.
REQ-017 IDLE: if a request is pending and tx_busy=0 -> ISSUE; busy=1 from acceptance cycle.
REQ-018 ISSUE: drive tx_data, assert tx_start for exactly one cycle -> WAIT_BUSY.
REQ-019 WAIT_BUSY: stay until tx_busy=1 -> WAIT_IDLE; tx_data held stable.
REQ-020 WAIT_IDLE: stay until tx_busy=0 -> NEXT.
REQ-021 NEXT: if more bytes in current job -> ISSUE with byte index +1; else job ends, frame_done pulses if job was a frame, -> IDLE (or directly ISSUE of the next pending job).
REQ-022 Byte index counter 0..3*NCH, reset to 0 at every job start; no wrap beyond 3*NCH.
REQ-023 Pending flags: one each for frame, run_on, run_off; set by the respective pulse, cleared when that job starts.
REQ-024 Requests arriving while busy SHALL be latched, not dropped; a second send_req during a frame sets the frame flag once (no counting).
REQ-025 Service priority at job boundary: run_off > run_on > frame.
REQ-026 run_on and run_off in the same cycle: only run_off latched.
REQ-027 Control bytes never interleave inside a frame; they wait for the commit byte.
REQ-028 busy=0 only when no job active and all pending flags clear.
REQ-029 tx_start never asserted while tx_busy=1 in ISSUE entry condition.

Reset
REQ-030 rst_n low: state IDLE, tx_data=8'h00, tx_start=0, busy=0, frame_done=0, index=0, pending flags and shadow register cleared.
REQ-031 Reset mid-frame aborts immediately; no further tx_start; pending requests discarded.

Structure
REQ-032 Shared package: header codes (2'b00,2'b01,2'b10,2'b11), control codes C0/C1/C2, state encoding, NCH default.
REQ-033 One combinational sub-module angle_byte_fmt: (index, shadow angles) -> byte per REQ-013.

Verification
REQ-034 Frame, angles A1=11'h7FF, others 0, TX model busy 10 cycles/byte -> 19 bytes: 01,7F,9F,02,40,80,...,06,40,80,C0; frame_done once.
REQ-035 angle_in changed to all 11'h155 two cycles after send_req -> frame still carries values captured at acceptance.
REQ-036 run_on during frame byte 5 -> C1 sent immediately after C0, never before; busy stays high throughout.
REQ-037 run_on and run_off same cycle, idle -> single byte C2 only.
REQ-038 rst_n low during WAIT_IDLE of byte 8 -> outputs at reset values, no tx_start until new request.
REQ-039 tx_busy held high 50 cycles at send_req -> no tx_start until tx_busy falls; then normal frame.

Source files
------------

// File: rtl/angle_frame_encoder_pkg.sv
// Shared codes, state encodings and sizing helpers for the angle frame encoder.
package angle_frame_encoder_pkg;

    localparam int unsigned NCH_DEFAULT = 6;

    localparam logic [1:0] HDR_CH  = 2'b00;
    localparam logic [1:0] HDR_LO  = 2'b01;
    localparam logic [1:0] HDR_HI  = 2'b10;
    localparam logic [1:0] HDR_CTL = 2'b11;

    localparam logic [7:0] CODE_COMMIT  = {HDR_CTL, 6'h00};
    localparam logic [7:0] CODE_RUN_ON  = {HDR_CTL, 6'h01};
    localparam logic [7:0] CODE_RUN_OFF = {HDR_CTL, 6'h02};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_IDLE,
        S_NEXT
    } state_e;

    typedef enum logic [1:0] {
        JOB_FRAME,
        JOB_RUN_ON,
        JOB_RUN_OFF
    } job_e;

    function automatic int unsigned idx_width(input int unsigned nch);
        return $clog2(3 * nch + 1);
    endfunction

endpackage

// File: rtl/angle_frame_encoder_fmt.sv
// Maps a frame byte index and the shadowed angles onto the wire byte of that slot.
module angle_byte_fmt
    import angle_frame_encoder_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEFAULT,
    parameter int unsigned IW  = idx_width(NCH_DEFAULT)
) (
    input  logic [IW-1:0]       idx,
    input  logic [NCH*11-1:0]   angles,
    output logic [7:0]          byte_o
);

    logic [10:0] ang;

    always_comb begin
        byte_o = CODE_COMMIT;
        ang    = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            ang = angles[k*11 +: 11];
            if (idx == IW'(3 * k))
                byte_o = {HDR_CH, 3'b000, 3'(k + 1)};
            else if (idx == IW'(3 * k + 1))
                byte_o = {HDR_LO, ang[5:0]};
            else if (idx == IW'(3 * k + 2))
                byte_o = {HDR_HI, 1'b0, ang[10:6]};
        end
    end

endmodule

// File: rtl/angle_frame_encoder.sv
// Serialises angle frames and run on/off control bytes onto a byte-wide UART handshake.
module angle_frame_encoder
    import angle_frame_encoder_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*11-1:0] angle_in,
    input  logic              send_req,
    input  logic              run_on,
    input  logic              run_off,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned    IW       = idx_width(NCH);
    localparam logic [IW-1:0]  LAST_IDX = IW'(3 * NCH);

    state_e            state_q, state_d;
    job_e              job_q, job_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NCH*11-1:0] shadow_q, shadow_d;
    logic              pend_frame_q, pend_frame_d;
    logic              pend_on_q, pend_on_d;
    logic              pend_off_q, pend_off_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    logic [7:0]        fmt_byte;
    logic              pf, pon, poff, can_start, last_byte;

    angle_byte_fmt #(.NCH(NCH), .IW(IW)) u_fmt (
        .idx    (idx_q),
        .angles (shadow_q),
        .byte_o (fmt_byte)
    );

    always_comb begin
        state_d      = state_q;
        job_d        = job_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        frame_done_d = 1'b0;
        can_start    = 1'b0;
        // Fresh pulses count as pending this cycle; run_off masks a coincident run_on.
        pf        = pend_frame_q | send_req;
        pon       = pend_on_q | (run_on & ~run_off);
        poff      = pend_off_q | run_off;
        last_byte = (job_q != JOB_FRAME) || (idx_q == LAST_IDX);

        case (state_q)
            S_IDLE: can_start = ~tx_busy;
            S_ISSUE: begin
                case (job_q)
                    JOB_RUN_OFF: tx_data_d = CODE_RUN_OFF;
                    JOB_RUN_ON:  tx_data_d = CODE_RUN_ON;
                    default:     tx_data_d = fmt_byte;
                endcase
                tx_start_d = 1'b1;
                state_d    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: if (tx_busy) state_d = S_WAIT_IDLE;
            S_WAIT_IDLE: if (!tx_busy) state_d = S_NEXT;
            S_NEXT: begin
                if (!tx_busy) begin
                    if (!last_byte) begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_ISSUE;
                    end else begin
                        frame_done_d = (job_q == JOB_FRAME);
                        can_start    = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Job boundary: control bytes always win over a waiting frame.
        if (can_start && (poff || pon || pf)) begin
            idx_d   = '0;
            state_d = S_ISSUE;
            if (poff) begin
                job_d = JOB_RUN_OFF;
                poff  = 1'b0;
            end else if (pon) begin
                job_d = JOB_RUN_ON;
                pon   = 1'b0;
            end else begin
                job_d    = JOB_FRAME;
                pf       = 1'b0;
                shadow_d = angle_in;
            end
        end

        pend_frame_d = pf;
        pend_on_d    = pon;
        pend_off_d   = poff;
        busy_d       = (state_d != S_IDLE) | pf | pon | poff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            job_q        <= JOB_FRAME;
            idx_q        <= '0;
            shadow_q     <= '0;
            pend_frame_q <= 1'b0;
            pend_on_q    <= 1'b0;
            pend_off_q   <= 1'b0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            job_q        <= job_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pend_frame_q <= pend_frame_d;
            pend_on_q    <= pend_on_d;
            pend_off_q   <= pend_off_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_angle_frame_encoder.sv
// Scoreboard bench: stimulus pushes expected bytes, a UART model/monitor pops and compares.
module tb_angle_frame_encoder;

    localparam int NCH      = 6;
    localparam int BUSY_CYC = 10;

    logic              clk;
    logic              rst_n;
    logic [NCH*11-1:0] angle_in;
    logic              send_req, run_on, run_off, tx_busy;
    logic [7:0]        tx_data;
    logic              tx_start, busy, frame_done;

    logic [7:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int byte_cnt = 0;
    int fd_cnt  = 0;
    int exp_fd  = 0;
    int cnt     = 0;
    logic hold  = 1'b0;

    angle_frame_encoder #(.NCH(NCH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .angle_in   (angle_in),
        .send_req   (send_req),
        .run_on     (run_on),
        .run_off    (run_off),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: channel code, low six bits, high five bits per channel, then commit.
    task automatic push_frame(input logic [NCH*11-1:0] ang);
        logic [10:0] v;
        for (int k = 1; k <= NCH; k++) begin
            v = ang[11*(k-1) +: 11];
            exp_q.push_back(8'(k));
            exp_q.push_back(8'h40 + 8'(v % 64));
            exp_q.push_back(8'h80 + 8'(v / 64));
        end
        exp_q.push_back(8'hC0);
        exp_fd++;
    endtask

    // UART model and monitor share one process so busy timing and checks are ordered.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (frame_done) fd_cnt++;
                if (tx_start) begin
                    byte_cnt++;
                    check("start_while_tx_busy", {31'b0, tx_busy}, 32'd0);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %0h expected none", tx_data);
                    end else begin
                        check("tx_byte", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
                    end
                    cnt = BUSY_CYC;
                end else if (cnt > 0) begin
                    cnt--;
                end
            end
            tx_busy = (cnt != 0) || hold;
        end
    end

    task automatic pulse(input bit s, input bit on, input bit off);
        @(negedge clk);
        send_req = s; run_on = on; run_off = off;
        @(negedge clk);
        send_req = 1'b0; run_on = 1'b0; run_off = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        if (i == 8000) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got busy=%0d pending=%0d expected idle", name, busy, exp_q.size());
        end
        repeat (3) @(negedge clk);
        check({name, "_frame_done_count"}, fd_cnt, exp_fd);
        check({name, "_busy_idle"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_bytes(input int target, input string name);
        int i;
        for (i = 0; i < 4000; i++) begin
            if (byte_cnt >= target) break;
            @(negedge clk);
        end
        if (i == 4000) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d bytes expected %0d", name, byte_cnt, target);
        end
    endtask

    task automatic rand_angles();
        for (int k = 0; k < NCH; k++) angle_in[11*k +: 11] = 11'($urandom);
    endtask

    initial begin
        int base, lows, b0;
        bit do_on, do_off, do_again;
        int c_on, c_off, c_again;
        logic [NCH*11-1:0] snap;

        rst_n = 1'b0; send_req = 1'b0; run_on = 1'b0; run_off = 1'b0;
        angle_in = '0;
        repeat (3) @(negedge clk);
        check("reset_tx_data", {24'b0, tx_data}, 32'd0);
        check("reset_tx_start", {31'b0, tx_start}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_frame_done", {31'b0, frame_done}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // A1 full scale, everything else zero
        angle_in = '0;
        angle_in[10:0] = 11'h7FF;
        push_frame(angle_in);
        pulse(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        wait_idle("frame_a1");

        // Inputs change after acceptance; the frame keeps the captured values
        rand_angles();
        push_frame(angle_in);
        pulse(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < NCH; k++) angle_in[11*k +: 11] = 11'h155;
        wait_idle("shadow");

        // run_on during byte 5 waits for the commit byte; busy never drops
        rand_angles();
        base = byte_cnt;
        push_frame(angle_in);
        pulse(1'b1, 1'b0, 1'b0);
        wait_bytes(base + 5, "byte5");
        exp_q.push_back(8'hC1);
        pulse(1'b0, 1'b1, 1'b0);
        lows = 0;
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            if (!busy) lows++;
        end
        check("busy_low_during_job", lows, 0);
        wait_idle("run_on_mid");

        // Coincident run_on and run_off from idle
        exp_q.push_back(8'hC2);
        pulse(1'b0, 1'b1, 1'b1);
        wait_idle("on_off_same");

        // Reset while the 8th byte is being transmitted
        rand_angles();
        base = byte_cnt;
        push_frame(angle_in);
        pulse(1'b1, 1'b0, 1'b0);
        wait_bytes(base + 8, "byte8");
        repeat (3) @(negedge clk);
        check("tx_busy_before_reset", {31'b0, tx_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_tx_data", {24'b0, tx_data}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_tx_start", {31'b0, tx_start}, 32'd0);
        exp_q.delete();
        exp_fd--;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        b0 = byte_cnt;
        repeat (40) @(negedge clk);
        check("no_start_after_abort", byte_cnt, b0);
        check("idle_after_abort", {31'b0, busy}, 32'd0);

        // Transmitter busy at request time
        hold = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rand_angles();
        b0 = byte_cnt;
        push_frame(angle_in);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        check("held_no_start", byte_cnt, b0);
        check("held_busy", {31'b0, busy}, 32'd1);
        hold = 1'b0;
        wait_idle("tx_busy_hold");

        // Random frames with extra requests landing mid-frame
        for (int it = 0; it < 8; it++) begin
            rand_angles();
            snap = angle_in;
            do_on = 1'($urandom); do_off = 1'($urandom); do_again = 1'($urandom);
            c_on = $urandom_range(1, 60);
            c_off = $urandom_range(1, 60);
            c_again = $urandom_range(1, 60);
            if (($urandom % 4) == 0) c_off = c_on;
            push_frame(snap);
            if (do_off) exp_q.push_back(8'hC2);
            if (do_on && !(do_off && c_on == c_off)) exp_q.push_back(8'hC1);
            if (do_again) push_frame(snap);
            pulse(1'b1, 1'b0, 1'b0);
            for (int c = 1; c <= 60; c++) begin
                send_req = do_again && (c == c_again);
                run_on   = do_on && (c == c_on);
                run_off  = do_off && (c == c_off);
                @(negedge clk);
            end
            send_req = 1'b0; run_on = 1'b0; run_off = 1'b0;
            wait_idle("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
